// File: rtl/divseq_pkg.sv
// divseq_pkg: shared types, defaults and period helper for the divider sequencer
// Contents: state_e (IDLE, LOAD, ARM, RUN), default WIDTH / MIN_PERIOD / WD_SLACK,
//           divseq_period() giving the divided period in clk cycles.
package divseq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_MIN_PERIOD = 2;
    localparam int DEF_WD_SLACK   = 4;
    localparam int MAX_W          = 16;

    // Up mode counts from div to the all-ones terminal value, down mode from div to zero.
    function automatic logic [MAX_W:0] divseq_period(input logic [MAX_W-1:0] div, input logic dir, input int width);
        logic [MAX_W:0] d;
        d = {1'b0, div};
        return dir ? d + (MAX_W+1)'(1) : ((MAX_W+1)'(1) << width) - d;
    endfunction

endpackage

// File: rtl/divseq_watchdog.sv
// divseq_watchdog: counts RUN cycles since the last terminal count and flags a missing one
// Ports: clk, rst_n (async active-low), run_i (sequencer in RUN), cout_i (terminal count),
//        period_i (active divided period), fire_o (period + WD_SLACK cycles passed without cout_i).
module divseq_watchdog #(
    parameter int WIDTH    = 8,
    parameter int WD_SLACK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run_i,
    input  logic           cout_i,
    input  logic [WIDTH:0] period_i,
    output logic           fire_o
);

    localparam int CW = WIDTH + 2;

    logic [CW-1:0] cnt_q, cnt_d, limit;

    // cnt_q is 0 in the first cycle after a restart, so the last tolerated cycle is limit.
    assign limit  = CW'(period_i) + CW'(WD_SLACK - 1);
    assign fire_o = run_i && !cout_i && cnt_q == limit;
    assign cnt_d  = (!run_i || cout_i || fire_o) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/divider_sequencer.sv
// divider_sequencer: loads, enables and glitch-free retunes an external up/down counter-divider
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_div/req_dir request handshake;
//        stop_req halts at the next terminal count; cd_cout terminal count from the divider;
//        cd_load_val/cd_init_n/cd_gn_n/cd_down_up drive the divider; busy (not IDLE);
//        cfg_err sticky reject flag; clr_err clears sticky flags.
// Build option: DIVSEQ_WATCHDOG_EN adds wd_err and a forced reload when cd_cout goes missing.
module divider_sequencer
    import divseq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD
`ifdef DIVSEQ_WATCHDOG_EN
    ,
    parameter int WD_SLACK   = DEF_WD_SLACK
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_div,
    input  logic             req_dir,
    input  logic             stop_req,
    input  logic             cd_cout,
    output logic [WIDTH-1:0] cd_load_val,
    output logic             cd_init_n,
    output logic             cd_gn_n,
    output logic             cd_down_up,
    output logic             busy,
    output logic             cfg_err,
`ifdef DIVSEQ_WATCHDOG_EN
    output logic             wd_err,
`endif
    input  logic             clr_err
);

    state_e           state_q;
    logic [WIDTH-1:0] load_q, pdiv_q;
    logic             dir_q, pdir_q, pend_q, stop_q, init_n_q, gn_n_q, err_q, err_d;
    logic [WIDTH:0]   req_period;
    logic             in_run, accept, good, stop_now, reload_now, wd_fire;

    assign req_period = (WIDTH+1)'(divseq_period(MAX_W'(req_div), req_dir, WIDTH));
    assign in_run     = state_q == RUN;
    assign req_ready  = state_q == IDLE || (in_run && !pend_q);
    assign busy       = state_q != IDLE;
    assign accept     = req_valid && req_ready;
    assign good       = accept && req_period >= (WIDTH+1)'(MIN_PERIOD);
    assign err_d      = (accept && !good) || (err_q && !clr_err);
    assign cfg_err    = err_q;

    // Terminal-count actions must hit the divider in the cout cycle itself, so they bypass the registers.
    assign stop_now    = in_run && cd_cout && stop_q;
    assign reload_now  = in_run && cd_cout && pend_q && !stop_q;
    assign cd_init_n   = init_n_q && !reload_now;
    assign cd_gn_n     = gn_n_q || stop_now;
    assign cd_load_val = reload_now ? pdiv_q : load_q;
    assign cd_down_up  = reload_now ? pdir_q : dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            load_q   <= '0;
            dir_q    <= 1'b0;
            pdiv_q   <= '0;
            pdir_q   <= 1'b0;
            pend_q   <= 1'b0;
            stop_q   <= 1'b0;
            init_n_q <= 1'b1;
            gn_n_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: if (good) begin
                    load_q   <= req_div;
                    dir_q    <= req_dir;
                    init_n_q <= 1'b0;
                    state_q  <= LOAD;
                end
                LOAD: begin
                    init_n_q <= 1'b1;
                    state_q  <= ARM;
                end
                ARM: begin
                    gn_n_q  <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (stop_req) stop_q <= 1'b1;
                    if (good) begin
                        pend_q <= 1'b1;
                        pdiv_q <= req_div;
                        pdir_q <= req_dir;
                    end
                    if (stop_now) begin
                        gn_n_q  <= 1'b1;
                        stop_q  <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (reload_now) begin
                        load_q <= pdiv_q;
                        dir_q  <= pdir_q;
                        pend_q <= 1'b0;
                    end else if (wd_fire) begin
                        // Missing cout: restart the divider from the active value.
                        gn_n_q   <= 1'b1;
                        init_n_q <= 1'b0;
                        state_q  <= LOAD;
                    end
                end
            endcase
        end
    end

`ifdef DIVSEQ_WATCHDOG_EN
    logic [WIDTH:0] act_period;
    logic           wd_err_q;

    assign act_period = (WIDTH+1)'(divseq_period(MAX_W'(load_q), dir_q, WIDTH));
    assign wd_err     = wd_err_q;

    divseq_watchdog #(.WIDTH(WIDTH), .WD_SLACK(WD_SLACK)) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (in_run),
        .cout_i   (cd_cout),
        .period_i (act_period),
        .fire_o   (wd_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_err_q <= 1'b0;
        else        wd_err_q <= wd_fire || (wd_err_q && !clr_err);
    end
`else
    assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: directed test-plan scenarios plus randomized traffic against a reference model
module tb_divider_sequencer;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req_valid = 1'b0, req_dir = 1'b0, stop_req = 1'b0, cd_cout = 1'b0, clr_err = 1'b0;
    logic [7:0] req_div = '0;
    logic       req_ready, cd_init_n, cd_gn_n, cd_down_up, busy, cfg_err;
    logic [7:0] cd_load_val;
`ifdef DIVSEQ_WATCHDOG_EN
    logic       wd_err;
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    int total = 0, bad = 0;

    divider_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_div     (req_div),
        .req_dir     (req_dir),
        .stop_req    (stop_req),
        .cd_cout     (cd_cout),
        .cd_load_val (cd_load_val),
        .cd_init_n   (cd_init_n),
        .cd_gn_n     (cd_gn_n),
        .cd_down_up  (cd_down_up),
        .busy        (busy),
        .cfg_err     (cfg_err),
`ifdef DIVSEQ_WATCHDOG_EN
        .wd_err      (wd_err),
`endif
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // Reference model: controller activity, warm-up countdown before counting, pending queue.
    bit m_act, m_stop, m_err, m_wderr;
    int m_warm, m_val, m_dir, m_last, cyc;
    int pq[$];

    function automatic int period(input int div, input bit dir);
        return dir ? div + 1 : 256 - div;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_stop = 0; m_err = 0; m_wderr = 0;
        m_warm = 0; m_val = 0; m_dir = 0; m_last = 0;
        pq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, cfg_err, 0);
        check({tag, "_init_n"}, cd_init_n, 1);
        check({tag, "_gn_n"}, cd_gn_n, 1);
        check({tag, "_load_val"}, cd_load_val, 0);
        check({tag, "_down_up"}, cd_down_up, 0);
`ifdef DIVSEQ_WATCHDOG_EN
        check({tag, "_wd_err"}, wd_err, 0);
`endif
    endtask

    task automatic cycle(input bit rv, input int rdiv, input bit rdir, input bit stp, input bit cout, input bit clr);
        bit run, ready, acc, isbad, stop_now, reload, wdfire;
        int ld, dr, ev;
        @(negedge clk);
        req_valid = rv; req_div = rdiv[7:0]; req_dir = rdir;
        stop_req = stp; cd_cout = cout; clr_err = clr;
        #1;
        run      = m_act && m_warm == 0;
        ready    = !m_act || (run && pq.size() == 0);
        acc      = rv && ready;
        isbad    = period(rdiv, rdir) < 2;
        stop_now = run && cout && m_stop;
        reload   = run && cout && !m_stop && pq.size() > 0;
        wdfire   = WD_ON && run && !cout && (cyc - m_last == period(m_val, m_dir[0]) + 4);
        ld       = reload ? pq[0] % 256 : m_val;
        dr       = reload ? pq[0] / 256 : m_dir;
        check("req_ready", req_ready, ready);
        check("busy", busy, m_act);
        check("cfg_err", cfg_err, m_err);
        check("cd_init_n", cd_init_n, !(m_act && m_warm == 2) && !reload);
        check("cd_gn_n", cd_gn_n, !run || stop_now);
        check("cd_load_val", cd_load_val, ld);
        check("cd_down_up", cd_down_up, dr);
`ifdef DIVSEQ_WATCHDOG_EN
        check("wd_err", wd_err, m_wderr);
`endif
        m_err   = (acc && isbad) || (m_err && !clr);
        m_wderr = wdfire || (m_wderr && !clr);
        if (!m_act) begin
            if (acc && !isbad) begin
                m_act = 1; m_warm = 2; m_val = rdiv; m_dir = rdir;
            end
        end else if (m_warm > 0) begin
            m_warm--;
            m_last = cyc;
        end else begin
            if (stp) m_stop = 1;
            if (acc && !isbad) pq.push_back(rdir * 256 + rdiv);
            if (cout) m_last = cyc;
            if (stop_now) begin
                m_act = 0; m_stop = 0; pq.delete();
            end else if (reload) begin
                ev = pq.pop_front();
                m_val = ev % 256; m_dir = ev / 256;
            end else if (wdfire) m_warm = 2;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int d;
        model_reset();
        cyc = 0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Start: 8F up, one load pulse, enable two cycles after acceptance.
        cycle(1, 'h8F, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_load_pulse", cd_init_n, 0);
        check("tp_load_val", cd_load_val, 'h8F);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_arm_gn_n", cd_gn_n, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_run_gn_n", cd_gn_n, 0);
        check("tp_run_busy", busy, 1);

        // Retune mid-period, applied in the cout cycle.
        cycle(1, 'hF0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_pend_ready", req_ready, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("tp_reload_init_n", cd_init_n, 0);
        check("tp_reload_val", cd_load_val, 'hF0);
        idle(2);

        // Period boundaries: FF up and 00 down rejected, FE up and 01 down accepted.
        cycle(1, 'hFF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_err_set", cfg_err, 1);
        check("tp_err_val_kept", cd_load_val, 'hF0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_err_clr", cfg_err, 0);
        cycle(1, 'hFE, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("tp_fe_accepted", cd_load_val, 'hFE);
        cycle(1, 'h00, 1, 0, 0, 1);
        cycle(1, 'h01, 1, 0, 0, 0);
        check("tp_down0_err", cfg_err, 1);
        cycle(0, 0, 0, 0, 1, 0);
        check("tp_down1_reload", cd_down_up, 1);

        // Stop at the next terminal count.
        cycle(0, 0, 0, 1, 0, 0);
        idle(3);
        check("tp_stop_wait", cd_gn_n, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("tp_stop_gn_n", cd_gn_n, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_stop_idle", busy, 0);

        // Pending full, stop latched and cout together: stop wins.
        cycle(1, 'h8F, 0, 0, 0, 0);
        idle(3);
        cycle(1, 'h10, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("tp_both_no_load", cd_init_n, 1);
        check("tp_both_gn_n", cd_gn_n, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_both_ready", req_ready, 1);
        check("tp_both_val", cd_load_val, 'h8F);

`ifdef DIVSEQ_WATCHDOG_EN
        // Down 03 gives period 4; cout withheld, watchdog fires 8 cycles into RUN.
        cycle(1, 'h03, 1, 0, 0, 0);
        idle(2);
        idle(8);
        check("tp_wd_quiet", wd_err, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("tp_wd_err", wd_err, 1);
        check("tp_wd_reload", cd_init_n, 0);
        check("tp_wd_val", cd_load_val, 'h03);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0);
        check("tp_wd_clr", wd_err, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge clk);
                req_valid = 0; stop_req = 0; cd_cout = 0; clr_err = 0;
                #2 rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_rst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            case ($urandom_range(0, 4))
                0:       d = 'h00;
                1:       d = 'h01;
                2:       d = 'hFE;
                3:       d = 'hFF;
                default: d = int'($urandom_range(0, 255));
            endcase
            cycle($urandom_range(0, 2) == 0, d, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
- Controller that configures and sequences an external loadable 8-bit up/down counter-divider (parallel load, active-low load strobe, active-low count enable, terminal-count pulse).
- Accepts divide-ratio requests over a valid/ready handshake, loads the divider and enables it.
- Retunes the divider only at a terminal count, so the divided clock never glitches.
- Sits between the clock-control register logic and the counter-divider, in the same clock domain as the divider.

Parameters:
- WIDTH, 8, divider load-value width.
- MIN_PERIOD, 2, smallest divided period in clk cycles that is accepted; requests below it are rejected.
- WD_SLACK, 4, extra clk cycles tolerated past the expected period before the watchdog fires (only with the macro).

Ports:
- clk  in  1  system clock; the divider runs on the same clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  a new configuration is offered.
- req_ready  out  1  the sequencer can accept a configuration.
- req_div  in  WIDTH  requested load value.
- req_dir  in  1  requested direction: 0 = up, 1 = down.
- stop_req  in  1  one-cycle pulse: halt the divider at its next terminal count.
- cd_cout  in  1  terminal-count pulse from the divider, one clk wide.
- cd_load_val  out  WIDTH  parallel load value driven to the divider.
- cd_init_n  out  1  active-low synchronous load strobe to the divider.
- cd_gn_n  out  1  active-low count enable to the divider.
- cd_down_up  out  1  direction to the divider.
- busy  out  1  high in any state other than IDLE.
- cfg_err  out  1  sticky; set when a request is rejected.
- clr_err  in  1  one-cycle pulse; clears the sticky error flags.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state = IDLE, cd_init_n = 1, cd_gn_n = 1, cd_load_val = 0, cd_down_up = 0.
  - req_ready = 1, busy = 0, cfg_err = 0, pending register empty.
- Period rule: up mode gives 2^WIDTH − req_div; down mode gives req_div + 1. Compute it in WIDTH+1 bits.
- A handshake completes on req_valid && req_ready. A request whose period is below MIN_PERIOD is consumed, sets cfg_err, and is otherwise ignored.
- IDLE:
  - req_ready = 1.
  - On a valid accepted request: latch req_div and req_dir into cd_load_val and cd_down_up, go to LOAD.
- LOAD (1 cycle): cd_init_n = 0, cd_gn_n stays 1. Next state is ARM.
- ARM (1 cycle): cd_init_n = 1. Next state is RUN, and cd_gn_n = 0 from RUN entry onward.
- RUN:
  - req_ready = 1 only while the pending register is empty; an accepted valid request fills it.
  - On cd_cout with pending full: drive cd_load_val and cd_down_up from pending, pulse cd_init_n = 0 in the same cycle, clear pending, stay in RUN.
  - On cd_cout with stop latched: cd_gn_n = 1, go to IDLE. Drop pending.
- stop_req in RUN sets a stop latch. It is ignored in IDLE, LOAD and ARM.
- Simultaneous events:
  - cd_cout together with stop latched and pending full: stop wins and pending is discarded.
  - Request accepted in the same cycle as cd_cout with pending empty: it is stored in pending and applied at the next cd_cout.
  - clr_err together with a new error: the error wins, flag ends at 1.
- cd_cout outside RUN is ignored.
- Reset mid-operation returns every output to its reset value immediately; the divider is disabled.

Optional Feature:
- DIVSEQ_WATCHDOG_EN defined:
  - Adds a port wd_err (out, 1), sticky, cleared by clr_err.
  - In RUN, a cycle counter restarts on every cd_cout and on RUN entry.
  - If it reaches the active period + WD_SLACK without seeing cd_cout, wd_err is set and the sequencer forces LOAD to reload the active value.
- Not defined: no counter, no wd_err port, no forced reload.

Decomposition:
- Package divseq_pkg holds:
  - the state enum (IDLE, LOAD, ARM, RUN);
  - a function computing the period from div, dir and WIDTH;
  - the default constants.
- One sub-module, divseq_watchdog (period counter plus compare), is instantiated only under DIVSEQ_WATCHDOG_EN.
- All other logic lives in one FSM module.

Test Plan:
- Reset, then req_div = 8'h8F, dir = 0 → one cd_init_n low pulse with load_val 8'h8F, then cd_gn_n low two cycles after acceptance; busy = 1.
- In RUN, request 8'hF0 up mid-period → req_ready drops; at the next cd_cout, cd_init_n pulses with 8'hF0 in the same cycle.
- Request req_div = 8'hFF, dir = 0 (period 1 < MIN_PERIOD) → request consumed, cfg_err = 1, outputs unchanged; clr_err clears the flag.
- stop_req mid-period → cd_gn_n stays 0 until cd_cout, goes to 1 that cycle; state = IDLE, busy = 0.
- Pending full, stop latched, and cd_cout all at once → no load pulse, cd_gn_n = 1, pending dropped.
- With DIVSEQ_WATCHDOG_EN, divider model withholds cd_cout → wd_err = 1 at period + 4 cycles, followed by a reload pulse.
